wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the pipeline writeback stage and a multi-cycle auxiliary result source (multiplier / late SRAM load). Pipeline writes have priority. Auxiliary results are buffered in a small FIFO and drained in idle write slots. A starvation guard forces a one-cycle pipeline stall so that buffered results always retire. The block sits between the WB stage output and the register file write port.

Parameters:
DEPTH, 4, auxiliary FIFO entries; power of two, >= 2
STARVE_LIMIT, 3, consecutive cycles in which the pipeline may win while the FIFO is non-empty before a stall is forced; >= 1
DATA_W, 32, write data width
REG_W, 4, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
pipe_wb_en  in  1  pipeline WB stage requests a write this cycle
pipe_dest  in  REG_W  pipeline destination register
pipe_value  in  DATA_W  pipeline write data
aux_valid  in  1  auxiliary result offered
aux_ready  out  1  FIFO accepts an auxiliary result this cycle
aux_dest  in  REG_W  auxiliary destination register
aux_value  in  DATA_W  auxiliary write data
stall_req  out  1  pipeline must hold its WB stage this cycle and re-present the same write next cycle
pending_mask  out  2**REG_W  bit i set while any FIFO entry targets register i
rf_wb_en  out  1  register-file write enable (registered)
rf_dest  out  REG_W  register-file write index (registered)
rf_value  out  DATA_W  register-file write data (registered)

Behaviour:
- Reset (rst=1 at clk edge): FIFO flushed, count=0, starve_cnt=0, rf_wb_en=0, rf_dest=0, rf_value=0.
- While rst=1: aux_ready=0 and stall_req=0. Reset mid-operation discards buffered entries; no partial write is issued.
- Push: aux_ready = !full. An entry {aux_dest, aux_value} is pushed when aux_valid && aux_ready. The source holds its data until accepted.
- Full FIFO: aux_ready stays low even if a pop occurs in the same cycle. There is no same-cycle full-through.
- stall_req = !empty && (starve_cnt == STARVE_LIMIT). It is combinational from registered state.
- Grant, evaluated each cycle:
  - If pipe_wb_en && !stall_req, the pipeline write is granted.
  - Otherwise, if the FIFO is non-empty, the FIFO head is popped.
  - Otherwise, no write occurs.
- During stall_req, pipe_wb_en is ignored. The pipeline contract guarantees the same write is re-presented next cycle.
- Output latency is 1 cycle. The granted {dest, value} appear on rf_* at the next clk edge with rf_wb_en=1. In a cycle with no grant, rf_wb_en=0 and rf_dest/rf_value hold their previous values.
- Auxiliary path minimum latency: push in cycle t, earliest pop in t+1, rf write visible after edge t+2. There is no bypass around the FIFO when it is empty.
- Simultaneous push and pop on a non-full FIFO: both happen; count is unchanged.
- FIFO order is strict; entries retire in push order.
- starve_cnt update at each edge:
  - If empty, or a pop is granted: starve_cnt = 0.
  - Else if the pipeline is granted: starve_cnt = min(starve_cnt+1, STARVE_LIMIT).
  - Else: unchanged.
- pending_mask is the OR of one-hot(dest) over valid FIFO entries, computed combinationally from FIFO state. The entry being popped is still included in the pop cycle; it clears after the edge. The hazard unit uses it to stall readers of pending registers.
- Same destination from both sources: no reordering or merging. Each write is issued in grant order. Correct ordering is the hazard unit's responsibility via pending_mask.
- Pointer wrap: read/write pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty are distinguished by a count register of width log2(DEPTH)+1.

Decomposition:
- Shared package contains:
  - REG_W and DATA_W constants.
  - wb_entry_t struct {dest[REG_W], value[DATA_W]}.
  - Default DEPTH and STARVE_LIMIT.
- One natural sub-module: wb_fifo, a synchronous FIFO with synchronous reset.
  - Ports: push/pop/full/empty.
  - Head entry output.
  - Flattened entry-valid and entry-dest vectors so pending_mask can be built in the parent.

Test Plan:
1. Reset, then pipe_wb_en=1, pipe_dest=3, pipe_value=0x11 for one cycle -> rf_wb_en=1, rf_dest=3, rf_value=0x11 one cycle later; aux_ready=1 and pending_mask=0 throughout.
2. Pipeline idle; aux_valid with dest=5, value=0xAA in cycle 0 -> pending_mask[5]=1 in cycle 1; rf write of R5=0xAA visible after the cycle-2 edge; pending_mask=0 after that.
3. Push 4 aux entries (dest 1,2,3,4) with pipe_wb_en=1 continuously:
   - aux_ready=0 once count=4.
   - After 3 pipeline wins, stall_req=1 for one cycle and R1 is written.
   - Pattern repeats; writes of R1..R4 appear in order.
4. FIFO full, aux_valid=1, pop in the same cycle -> no push that cycle; push accepted the next cycle; no entry lost or duplicated (scoreboard check).
5. FIFO holding 2 entries, rst asserted for 1 cycle mid-drain -> rf_wb_en=0 and pending_mask=0 after the edge; aux_ready=0 during reset; the removed entries are never written.
6. Random pipe/aux traffic for 10k cycles vs a reference model -> every accepted write appears exactly once; aux order preserved; stall_req never asserted while the FIFO is empty.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback port arbiter.
//   REG_W / DATA_W      : register index and data widths of the register-file write port
//   DEFAULT_DEPTH       : default auxiliary FIFO depth
//   DEFAULT_STARVE_LIMIT: default number of pipeline wins tolerated while aux results wait
//   wb_entry_t          : one pending register write {dest, value}
package wb_port_arbiter_pkg;

    localparam int unsigned REG_W                = 4;
    localparam int unsigned DATA_W               = 32;
    localparam int unsigned NUM_REGS             = 2 ** REG_W;
    localparam int unsigned DEFAULT_DEPTH        = 4;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 3;

    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [REG_W-1:0] dest);
        return NUM_REGS'(1) << dest;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering auxiliary register writes.
//   clk, rst     : clock and synchronous active-high reset (flushes all entries)
//   push         : write push_entry at the tail (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   full, empty  : occupancy flags derived from the count register
//   head         : entry at the read pointer
//   entry_valid  : per-slot occupancy, indexed by physical slot
//   entry_dest   : per-slot destination register, flattened REG_W bits per slot
module wb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output wb_entry_t              head,
    output logic [DEPTH-1:0]       entry_valid,
    output logic [DEPTH*REG_W-1:0] entry_dest
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: a slot is only observed once the count covers it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        entry_dest  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, offset} < count_q);
            entry_dest[i*REG_W +: REG_W] = mem[i].dest;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB stage and
// buffered auxiliary results (multiplier, late loads).
//   clk, rst                         : clock, synchronous active-high reset
//   pipe_wb_en, pipe_dest, pipe_value: pipeline write request (highest priority)
//   aux_valid, aux_dest, aux_value   : auxiliary result offer; aux_ready accepts it
//   stall_req                        : pipeline must hold and re-present its write
//   pending_mask                     : registers targeted by any buffered aux write
//   rf_wb_en, rf_dest, rf_value      : registered register-file write port
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipe_wb_en,
    input  logic [REG_W-1:0]    pipe_dest,
    input  logic [DATA_W-1:0]   pipe_value,
    input  logic                aux_valid,
    output logic                aux_ready,
    input  logic [REG_W-1:0]    aux_dest,
    input  logic [DATA_W-1:0]   aux_value,
    output logic                stall_req,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                rf_wb_en,
    output logic [REG_W-1:0]    rf_dest,
    output logic [DATA_W-1:0]   rf_value
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                   fifo_full;
    logic                   fifo_empty;
    wb_entry_t              fifo_head;
    wb_entry_t              aux_entry;
    logic [DEPTH-1:0]       fifo_valid;
    logic [DEPTH*REG_W-1:0] fifo_dest;

    logic                   pipe_grant;
    logic                   pop;
    logic                   push;
    logic [STARVE_W-1:0]    starve_q;
    logic [STARVE_W-1:0]    starve_d;

    logic                   rf_wb_en_q;
    logic [REG_W-1:0]       rf_dest_q;
    logic [DATA_W-1:0]      rf_value_q;

    assign aux_entry = '{dest: aux_dest, value: aux_value};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (aux_entry),
        .pop         (pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head        (fifo_head),
        .entry_valid (fifo_valid),
        .entry_dest  (fifo_dest)
    );

    always_comb begin
        aux_ready  = !rst && !fifo_full;
        stall_req  = !rst && !fifo_empty && (starve_q == STARVE_W'(STARVE_LIMIT));
        push       = aux_valid && aux_ready;
        pipe_grant = !rst && pipe_wb_en && !stall_req;
        pop        = !rst && !pipe_grant && !fifo_empty;

        // The counter only measures waiting of a non-empty FIFO; any drain restarts it.
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (pipe_grant && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q   <= '0;
            rf_wb_en_q <= 1'b0;
            rf_dest_q  <= '0;
            rf_value_q <= '0;
        end else begin
            starve_q <= starve_d;
            if (pipe_grant) begin
                rf_wb_en_q <= 1'b1;
                rf_dest_q  <= pipe_dest;
                rf_value_q <= pipe_value;
            end else if (pop) begin
                rf_wb_en_q <= 1'b1;
                rf_dest_q  <= fifo_head.dest;
                rf_value_q <= fifo_head.value;
            end else begin
                rf_wb_en_q <= 1'b0;
            end
        end
    end

    assign rf_wb_en = rf_wb_en_q;
    assign rf_dest  = rf_dest_q;
    assign rf_value = rf_value_q;

    // The head being popped stays visible this cycle so readers stall until it lands.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) begin
                pending_mask = pending_mask | dest_onehot(fifo_dest[i*REG_W +: REG_W]);
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a queue-based model of the write-port rules is stepped once
// per cycle and every output is compared against it, plus literal expectations for the
// directed scenarios and an aux-order scoreboard during random traffic.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                pipe_wb_en;
    logic [REG_W-1:0]    pipe_dest;
    logic [DATA_W-1:0]   pipe_value;
    logic                aux_valid;
    logic                aux_ready;
    logic [REG_W-1:0]    aux_dest;
    logic [DATA_W-1:0]   aux_value;
    logic                stall_req;
    logic [NUM_REGS-1:0] pending_mask;
    logic                rf_wb_en;
    logic [REG_W-1:0]    rf_dest;
    logic [DATA_W-1:0]   rf_value;

    wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_dest    (pipe_dest),
        .pipe_value   (pipe_value),
        .aux_valid    (aux_valid),
        .aux_ready    (aux_ready),
        .aux_dest     (aux_dest),
        .aux_value    (aux_value),
        .stall_req    (stall_req),
        .pending_mask (pending_mask),
        .rf_wb_en     (rf_wb_en),
        .rf_dest      (rf_dest),
        .rf_value     (rf_value)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state
    wb_entry_t         mq[$];
    wb_entry_t         sbq[$];
    int                m_starve;
    logic              m_en;
    logic [REG_W-1:0]  m_dest;
    logic [DATA_W-1:0] m_val;
    logic              last_stall;
    logic              last_ready;
    bit                sb_on;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare combinational outputs mid-cycle, advance model, compare rf_* after edge.
    task automatic tick();
        logic [NUM_REGS-1:0] e_mask;
        logic                e_ready;
        logic                e_stall;
        logic                pg;
        logic                pp;
        logic                was_empty;
        wb_entry_t           h;
        wb_entry_t           s;
        @(negedge clk);
        e_mask = '0;
        foreach (mq[k]) e_mask[mq[k].dest] = 1'b1;
        e_ready = !rst && (mq.size() < DEPTH);
        e_stall = !rst && (mq.size() != 0) && (m_starve == LIMIT);
        chk("aux_ready", 64'(aux_ready), 64'(e_ready));
        chk("stall_req", 64'(stall_req), 64'(e_stall));
        chk("pending_mask", 64'(pending_mask), 64'(e_mask));
        pg = !rst && pipe_wb_en && !e_stall;
        pp = !rst && !pg && (mq.size() != 0);
        if (rst) begin
            mq.delete();
            sbq.delete();
            m_starve = 0;
            m_en     = 1'b0;
            m_dest   = '0;
            m_val    = '0;
        end else begin
            was_empty = (mq.size() == 0);
            if (pg) begin
                m_en = 1'b1; m_dest = pipe_dest; m_val = pipe_value;
            end else if (pp) begin
                h = mq.pop_front();
                m_en = 1'b1; m_dest = h.dest; m_val = h.value;
            end else begin
                m_en = 1'b0;
            end
            if (aux_valid && e_ready) begin
                mq.push_back('{dest: aux_dest, value: aux_value});
                if (sb_on) sbq.push_back('{dest: aux_dest, value: aux_value});
            end
            if (was_empty || pp) m_starve = 0;
            else if (pg) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        end
        last_stall = e_stall;
        last_ready = e_ready;
        @(posedge clk);
        #1;
        chk("rf_wb_en", 64'(rf_wb_en), 64'(m_en));
        chk("rf_dest", 64'(rf_dest), 64'(m_dest));
        chk("rf_value", 64'(rf_value), 64'(m_val));
        // Aux values carry bit 31 set during random traffic; they must retire in push order.
        if (sb_on && rf_wb_en === 1'b1 && rf_value[31] === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_aux", 64'(rf_value), 64'(0));
            end else begin
                s = sbq.pop_front();
                chk("sb_aux_order", {28'(0), rf_dest, rf_value}, {28'(0), s.dest, s.value});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; pipe_wb_en = 1'b0; pipe_dest = '0; pipe_value = '0;
        aux_valid = 1'b0; aux_dest = '0; aux_value = '0; sb_on = 1'b0;
        last_stall = 1'b0; last_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete(); sbq.delete();
        m_starve = 0; m_en = 1'b0; m_dest = '0; m_val = '0;
        chk("reset_rf_wb_en", 64'(rf_wb_en), 64'(0));
        chk("reset_rf_dest", 64'(rf_dest), 64'(0));
        chk("reset_rf_value", 64'(rf_value), 64'(0));
        chk("reset_aux_ready", 64'(aux_ready), 64'(0));
        chk("reset_stall", 64'(stall_req), 64'(0));
        chk("reset_mask", 64'(pending_mask), 64'(0));
        rst = 1'b0;

        // Pipeline write lands one cycle later.
        pipe_wb_en = 1'b1; pipe_dest = 4'd3; pipe_value = 32'h11;
        #1;
        chk("t1_aux_ready", 64'(aux_ready), 64'(1));
        chk("t1_mask", 64'(pending_mask), 64'(0));
        tick();
        pipe_wb_en = 1'b0;
        chk("t1_rf_wb_en", 64'(rf_wb_en), 64'(1));
        chk("t1_rf_dest", 64'(rf_dest), 64'(3));
        chk("t1_rf_value", 64'(rf_value), 64'(32'h11));

        // Single aux result: buffered one cycle, then written.
        aux_valid = 1'b1; aux_dest = 4'd5; aux_value = 32'hAA;
        tick();
        aux_valid = 1'b0;
        #1;
        chk("t2_mask_set", 64'(pending_mask), 64'(16'h0020));
        chk("t2_no_write", 64'(rf_wb_en), 64'(0));
        chk("t2_dest_hold", 64'(rf_dest), 64'(3));
        tick();
        chk("t2_rf_wb_en", 64'(rf_wb_en), 64'(1));
        chk("t2_rf_dest", 64'(rf_dest), 64'(5));
        chk("t2_rf_value", 64'(rf_value), 64'(32'hAA));
        #1;
        chk("t2_mask_clear", 64'(pending_mask), 64'(0));
        tick();

        // Fill under continuous pipeline traffic; starvation forces a stall.
        pipe_wb_en = 1'b1; pipe_dest = 4'hE; pipe_value = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            aux_valid = 1'b1; aux_dest = 4'(k + 1); aux_value = 32'h101 + 32'(k);
            tick();
        end
        aux_dest = 4'd6; aux_value = 32'h106;
        #1;
        chk("t3_full_ready", 64'(aux_ready), 64'(0));
        chk("t3_stall", 64'(stall_req), 64'(1));
        chk("t3_mask", 64'(pending_mask), 64'(16'h001E));
        tick();
        chk("t3_stall_write_en", 64'(rf_wb_en), 64'(1));
        chk("t3_stall_write_dest", 64'(rf_dest), 64'(1));
        chk("t3_stall_write_value", 64'(rf_value), 64'(32'h101));
        #1;
        chk("t4_ready_after_pop", 64'(aux_ready), 64'(1));
        tick();
        aux_valid = 1'b0;
        repeat (14) tick();
        pipe_wb_en = 1'b0;
        repeat (8) tick();
        chk("t3_drained_mask", 64'(pending_mask), 64'(0));

        // Reset mid-drain discards buffered entries.
        pipe_wb_en = 1'b1; pipe_dest = 4'd7; pipe_value = 32'h77;
        aux_valid = 1'b1; aux_dest = 4'd9; aux_value = 32'h99;
        tick();
        aux_dest = 4'd10; aux_value = 32'hA0;
        tick();
        rst = 1'b1; pipe_wb_en = 1'b0; aux_dest = 4'd11; aux_value = 32'hB0;
        #1;
        chk("t5_ready_in_reset", 64'(aux_ready), 64'(0));
        chk("t5_stall_in_reset", 64'(stall_req), 64'(0));
        chk("t5_mask_in_reset", 64'(pending_mask), 64'(16'h0600));
        tick();
        rst = 1'b0; aux_valid = 1'b0;
        #1;
        chk("t5_rf_wb_en", 64'(rf_wb_en), 64'(0));
        chk("t5_mask_after", 64'(pending_mask), 64'(0));
        repeat (3) tick();
        chk("t5_no_stale_write", 64'(rf_wb_en), 64'(0));

        // Random traffic honouring the hold contracts of both sources.
        sb_on = 1'b1;
        sbq.delete();
        for (int n = 0; n < 10000; n++) begin
            if (!(pipe_wb_en && last_stall)) begin
                pipe_wb_en = ($urandom_range(0, 9) < 6);
                pipe_dest  = 4'($urandom_range(0, 15));
                pipe_value = $urandom() & 32'h7FFF_FFFF;
            end
            if (!(aux_valid && !last_ready)) begin
                aux_valid = ($urandom_range(0, 1) == 1);
                aux_dest  = 4'($urandom_range(0, 15));
                aux_value = $urandom() | 32'h8000_0000;
            end
            tick();
        end
        pipe_wb_en = 1'b0;
        aux_valid  = 1'b0;
        repeat (12) tick();
        chk("sb_drained", 64'(sbq.size()), 64'(0));
        chk("model_drained", 64'(mq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
